// File: rtl/alpha_pkg.sv
// alpha_pkg: cipher letter codes and the membership test shared by the feeder and the decoder
package alpha_pkg;
  localparam logic [7:0] CH_A = 8'd65;
  localparam logic [7:0] CH_D = 8'd68;
  localparam logic [7:0] CH_E = 8'd69;
  localparam logic [7:0] CH_H = 8'd72;
  localparam logic [7:0] CH_I = 8'd73;
  localparam logic [7:0] CH_L = 8'd76;
  localparam logic [7:0] CH_N = 8'd78;
  localparam logic [7:0] CH_O = 8'd79;
  localparam logic [7:0] CH_R = 8'd82;
  localparam logic [7:0] CH_S = 8'd83;
  localparam logic [7:0] CH_T = 8'd84;
  localparam logic [7:0] CH_U = 8'd85;
  localparam int NUM_LETTERS = 12;
  localparam int REJECT_CNT_W = 16;
  localparam logic [NUM_LETTERS-1:0][7:0] CIPHER_CODES =
    {CH_E, CH_T, CH_A, CH_O, CH_I, CH_N, CH_S, CH_H, CH_R, CH_D, CH_L, CH_U};
  function automatic logic is_cipher_letter(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_LETTERS; i++) hit |= (b == CIPHER_CODES[i]);
    return hit;
  endfunction
endpackage

// File: rtl/cipher_fifo.sv
// cipher_fifo: letter buffer with wrapping pointers; full/empty come from level, flush wins over pop
module cipher_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [7:0]                 din,
  output logic [7:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr;
  logic [AW-1:0] rd;
  assign dout = mem[rd];
  // storage write at the tail
  always_ff @(posedge clk) begin
    if (push) mem[wr] <= din;
  end
  // pointers and occupancy; a flush voids any concurrent pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr    <= '0;
      rd    <= '0;
      level <= '0;
    end else if (flush) begin
      wr    <= '0;
      rd    <= '0;
      level <= '0;
    end else begin
      if (push) wr <= wr + AW'(1);
      if (pop) rd <= rd + AW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end
endmodule

// File: rtl/cipher_byte_feeder.sv
// cipher_byte_feeder: filters a raw byte stream down to cipher letters and buffers them for the decoder
// Optional CIPHER_LOWERCASE_FOLD_EN folds 'a'..'z' to uppercase before filtering.
module cipher_byte_feeder
  import alpha_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_byte,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 cipher,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       reject_pulse,
  output logic [REJECT_CNT_W-1:0]    reject_cnt
);
  localparam int LW = $clog2(DEPTH+1);
  logic [7:0] folded;
  logic [7:0] head;
  logic       accept;
  logic       letter;
  logic       push;
  logic       reject;
  // fold, filter and handshake decode; readiness never looks at out_ready
  always_comb begin
`ifdef CIPHER_LOWERCASE_FOLD_EN
    folded = (in_byte >= 8'd97 && in_byte <= 8'd122) ? (in_byte & 8'hDF) : in_byte;
`else
    folded = in_byte;
`endif
    in_ready  = (level != LW'(DEPTH)) && !flush;
    accept    = in_valid && in_ready;
    letter    = is_cipher_letter(folded);
    push      = accept && letter;
    reject    = accept && !letter;
    out_valid = level != '0;
    cipher    = out_valid ? head : CH_E;
  end
  cipher_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (out_valid && out_ready),
    .flush (flush),
    .din   (folded),
    .dout  (head),
    .level (level)
  );
  // registered reject diagnostics with a saturating count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reject_pulse <= 1'b0;
      reject_cnt   <= '0;
    end else begin
      reject_pulse <= reject;
      if (reject && reject_cnt != '1) reject_cnt <= reject_cnt + REJECT_CNT_W'(1);
    end
  end
endmodule
